motor_cmd_sequencer: RTL

- AXI4-Lite master that sequences motor-driver register writes.
- Commands arrive on a valid/ready stream from the Bluetooth command decoder and are buffered in a small FIFO.
- Each command is issued as a single AXI4-Lite write to one of the four 32-bit registers of the motor-driver slave.
- Write responses are checked, and errors are counted and flagged to software/status logic.

---
 rtl/motor_drv_pkg.sv | 24 ++
 rtl/motor_cmd_sequencer_if.sv | 29 ++
 rtl/motor_cmd_fifo.sv | 45 ++++
 rtl/motor_cmd_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/motor_drv_pkg.sv
// Shared definitions for the motor-driver command sequencer: register map,
// AXI response codes, sequencer states and the register address helper.
package motor_drv_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_SPEED_L = 2'd1;
  localparam logic [1:0] REG_SPEED_R = 2'd2;
  localparam logic [1:0] REG_DIR     = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ADDR_DATA = 2'd1,
    ST_RESP      = 2'd2
  } seq_state_e;

  // Byte address of a 32-bit driver register; wraps modulo 2^32 by design.
  function automatic logic [31:0] reg_addr(input logic [31:0] base, input logic [1:0] idx);
    return base + {28'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/motor_cmd_sequencer_if.sv
// AXI4-Lite write-only channel bundle between the sequencer (master) and the
// motor-driver register slave.
interface motor_cmd_sequencer_if;
  logic [31:0] M_AXI_AWADDR;
  logic [2:0]  M_AXI_AWPROT;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    output M_AXI_BREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
    input  M_AXI_BREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID
  );
endinterface

// File: rtl/motor_cmd_fifo.sv
// Synchronous command FIFO; read data is the head entry (show-ahead) so the
// sequencer can load the AXI registers in the same cycle it pops.
module motor_cmd_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_XOR = {1'b1, {AW{1'b0}}};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = ((wr_ptr_q ^ rd_ptr_q) == FULL_XOR);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Storage array, no reset needed: pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  // Pointer update; reset discards all queued entries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end
endmodule

// File: rtl/motor_cmd_sequencer.sv
// Motor command sequencer: buffers register-write commands and issues each as
// one AXI4-Lite write, counting error responses.
// Optional idle watchdog stop-write enabled by defining MOTOR_CMD_SEQ_WDOG_EN.
//
// state      | meaning
// ST_IDLE    | waiting for a queued command (or watchdog) to issue
// ST_ADDR_DATA | AW and/or W still waiting for READY
// ST_RESP    | BREADY high, waiting for BVALID
module motor_cmd_sequencer
  import motor_drv_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [31:0] WDOG_CYCLES = 32'd50_000_000
) (
  input  logic                         ACLK,
  input  logic                         ARESET,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_reg,
  input  logic [31:0]                  cmd_data,
  motor_cmd_sequencer_if.master        m_axi,
  output logic                         busy,
  output logic                         err_pulse,
  output logic [7:0]                   err_count
`ifdef MOTOR_CMD_SEQ_WDOG_EN
  , output logic                       wdog_fired
`endif
);

  seq_state_e  state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d;
  logic        err_pulse_q, err_pulse_d;
  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        push, pop, fifo_full, fifo_empty;
  logic [33:0] fifo_rdata;
  logic        wdog_issue;

  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  motor_cmd_fifo #(.WIDTH(34), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (ACLK),
    .rst     (ARESET),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({cmd_reg, cmd_data}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef MOTOR_CMD_SEQ_WDOG_EN
  logic [31:0] wdog_cnt_q;
  logic        wdog_fire, wdog_fired_q;

  // An accepted command in the same cycle wins over the watchdog.
  assign wdog_fire  = (wdog_cnt_q == WDOG_CYCLES) && !push;
  assign wdog_fired = wdog_fired_q;

  // Idle counter: cleared by any accepted command or by a stop write, holds at terminal count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wdog_cnt_q   <= '0;
      wdog_fired_q <= 1'b0;
    end else begin
      wdog_fired_q <= wdog_issue;
      if (push || wdog_issue)            wdog_cnt_q <= '0;
      else if (wdog_cnt_q != WDOG_CYCLES) wdog_cnt_q <= wdog_cnt_q + 32'd1;
    end
  end
`else
  logic wdog_unused;
  assign wdog_unused = ^WDOG_CYCLES;
`endif

  // Next-state and registered-output logic for the write sequencer.
  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    pop         = 1'b0;
    wdog_issue  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          awaddr_d  = reg_addr(BASE_ADDR, fifo_rdata[33:32]);
          wdata_d   = fifo_rdata[31:0];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = ST_ADDR_DATA;
        end
`ifdef MOTOR_CMD_SEQ_WDOG_EN
        else if (wdog_fire) begin
          wdog_issue = 1'b1;
          awaddr_d   = reg_addr(BASE_ADDR, REG_CTRL);
          wdata_d    = 32'h0000_0000;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          state_d    = ST_ADDR_DATA;
        end
`endif
      end
      ST_ADDR_DATA: begin
        if (m_axi.M_AXI_AWREADY) awvalid_d = 1'b0;
        if (m_axi.M_AXI_WREADY)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi.M_AXI_BVALID) begin
          bready_d = 1'b0;
          state_d  = ST_IDLE;
          if (m_axi.M_AXI_BRESP != RESP_OKAY) begin
            err_pulse_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and AXI output registers; reset abandons any transaction in flight.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= ST_IDLE;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      err_cnt_q   <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = 4'hF;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign busy      = !fifo_empty || (state_q != ST_IDLE);
  assign err_pulse = err_pulse_q;
  assign err_count = err_cnt_q;

endmodule
